// File: rtl/itcm_arb.sv
// itcm_arb: shares the single-port instruction TCM between the CPU fetch
// stage and the CPU data/loader port. Fetch has priority. A starvation
// guard forces a data-port grant after STARVE consecutive denied cycles.
// Read data and write acks are returned one cycle after the grant to
// whichever port owned the access. Wait counters feed the trace bench.
//
// owner state | meaning
// ------------+-------------------------------------------------
// OWN_IDLE    | no access issued last cycle, no response due
// OWN_IF_RD   | fetch read issued last cycle, data on mem_rdata
// OWN_DP_RD   | data-port read issued last cycle, data on mem_rdata
// OWN_DP_WR   | data-port write issued last cycle, ack with zero data
module itcm_arb #(
    parameter int AW     = 14,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          dp_req,
    input  logic          dp_we,
    input  logic [3:0]    dp_be,
    input  logic [AW-1:0] dp_addr,
    input  logic [31:0]   dp_wdata,
    output logic          dp_gnt,
    output logic          dp_rvalid,
    output logic [31:0]   dp_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   cnt_if_wait,
    output logic [31:0]   cnt_dp_wait
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_DP_RD = 2'd2,
        OWN_DP_WR = 2'd3
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    owner_t      r_owner;
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_cnt_if_wait;
    logic [31:0] r_cnt_dp_wait;
    logic        w_force;
    logic        w_if_gnt;
    logic        w_dp_gnt;

    // Grant decision; both grants are held off while reset is asserted.
    always_comb begin
        w_force  = (r_starve_cnt == STARVE_LIM);
        w_if_gnt = reset_n & if_req & ~(dp_req & w_force);
        w_dp_gnt = reset_n & dp_req & ~w_if_gnt;
    end

    assign if_gnt = w_if_gnt;
    assign dp_gnt = w_dp_gnt;

    // Steer the granted port onto the memory; bus is all-zero when idle.
    always_comb begin
        mem_en    = w_if_gnt | w_dp_gnt;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_if_gnt) begin
            mem_addr = if_addr;
        end else if (w_dp_gnt) begin
            mem_addr  = dp_addr;
            mem_wdata = dp_wdata;
            if (dp_we) begin
                mem_we = dp_be;
            end
        end
    end

    // Response owner: records who was granted so the 1-cycle-late data is routed back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_IDLE;
        end else if (w_if_gnt) begin
            r_owner <= OWN_IF_RD;
        end else if (w_dp_gnt) begin
            r_owner <= dp_we ? OWN_DP_WR : OWN_DP_RD;
        end else begin
            r_owner <= OWN_IDLE;
        end
    end

    // Starvation counter: counts consecutive denied data-port cycles, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dp_gnt || !dp_req) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Contention counters; free-running 32-bit, wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_if_wait <= 32'h0;
            r_cnt_dp_wait <= 32'h0;
        end else begin
            if (if_req && !w_if_gnt) begin
                r_cnt_if_wait <= r_cnt_if_wait + 32'd1;
            end
            if (dp_req && !w_dp_gnt) begin
                r_cnt_dp_wait <= r_cnt_dp_wait + 32'd1;
            end
        end
    end

    assign cnt_if_wait = r_cnt_if_wait;
    assign cnt_dp_wait = r_cnt_dp_wait;

    // Response decode; write acks carry zero data.
    always_comb begin
        if_rvalid = (r_owner == OWN_IF_RD);
        dp_rvalid = (r_owner == OWN_DP_RD) || (r_owner == OWN_DP_WR);
        if_rdata  = (r_owner == OWN_IF_RD) ? mem_rdata : 32'h0;
        dp_rdata  = (r_owner == OWN_DP_RD) ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_itcm_arb.sv
// Directed bench for itcm_arb with a behavioural single-port ITCM model.
module tb_itcm_arb;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          dp_req;
    logic          dp_we;
    logic [3:0]    dp_be;
    logic [AW-1:0] dp_addr;
    logic [31:0]   dp_wdata;
    logic          dp_gnt;
    logic          dp_rvalid;
    logic [31:0]   dp_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   cnt_if_wait;
    logic [31:0]   cnt_dp_wait;

    int n_vec = 0;
    int n_err = 0;

    itcm_arb #(.AW(AW), .STARVE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_be(dp_be), .dp_addr(dp_addr),
        .dp_wdata(dp_wdata), .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid),
        .dp_rdata(dp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cnt_if_wait(cnt_if_wait), .cnt_dp_wait(cnt_dp_wait)
    );

    always #5 clk = ~clk;

    // ITCM model with a preload port used only while the arbiter is idle.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                mem_rdata <= 32'h0;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [3:0]    be;
        logic [AW-1:0] da;
        logic [31:0]   wd;
        logic          e_ig;
        logic          e_dg;
        logic [3:0]    e_we;
        logic [AW-1:0] e_ma;
        logic [31:0]   e_mwd;
        logic          e_iv;
        logic [31:0]   e_id;
        logic          e_dv;
        logic [31:0]   e_dd;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic ir, input logic [AW-1:0] ia,
        input logic dr, input logic dw, input logic [3:0] be,
        input logic [AW-1:0] da, input logic [31:0] wd,
        input logic e_ig, input logic e_dg, input logic [3:0] e_we,
        input logic [AW-1:0] e_ma, input logic [31:0] e_mwd,
        input logic e_iv, input logic [31:0] e_id,
        input logic e_dv, input logic [31:0] e_dd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.be = be; v.da = da; v.wd = wd;
        v.e_ig = e_ig; v.e_dg = e_dg; v.e_we = e_we; v.e_ma = e_ma; v.e_mwd = e_mwd;
        v.e_iv = e_iv; v.e_id = e_id; v.e_dv = e_dv; v.e_dd = e_dd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        dp_req = 1'b0; dp_we = 1'b0; dp_be = 4'b0; dp_addr = '0; dp_wdata = 32'h0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [118:0] got_b, exp_b;

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        if_req  = 1'b1;
        dp_req  = 1'b1;

        // Reset state with both requests active.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst if_gnt", 32'(if_gnt), 32'd0);
        chk("rst dp_gnt", 32'(dp_gnt), 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst rvalids", {30'd0, if_rvalid, dp_rvalid}, 32'd0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst dp_rdata", dp_rdata, 32'h0);
        chk("rst cnt_if_wait", cnt_if_wait, 32'h0);
        chk("rst cnt_dp_wait", cnt_dp_wait, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release if_gnt", 32'(if_gnt), 32'd1);
        chk("release dp_gnt", 32'(dp_gnt), 32'd0);
        idle_inputs();

        // Table: fetch stream, data-port read, contention, partial write.
        for (int i = 0; i < 8; i++) begin
            preload(AW'(i), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b1, AW'(i), 1'b0, 1'b0, 4'h0, '0, 32'h0,
                         1'b1, 1'b0, 4'h0, AW'(i), 32'h0,
                         (i > 0), (i > 0) ? 32'h1000 + 32'(i) - 32'd1 : 32'h0,
                         1'b0, 32'h0);
        end
        vecs[8]  = mk(0, '0, 0, 0, 4'h0, '0, 32'h0,  0, 0, 4'h0, '0, 32'h0,  1, 32'h1007, 0, 32'h0);
        vecs[9]  = mk(0, '0, 0, 0, 4'h0, '0, 32'h0,  0, 0, 4'h0, '0, 32'h0,  0, 32'h0,    0, 32'h0);
        vecs[10] = mk(0, '0, 1, 0, 4'h0, 14'd3, 32'h0,  0, 1, 4'h0, 14'd3, 32'h0,  0, 32'h0, 0, 32'h0);
        vecs[11] = mk(0, '0, 0, 0, 4'h0, '0, 32'h0,  0, 0, 4'h0, '0, 32'h0,  0, 32'h0,    1, 32'h1003);
        vecs[12] = mk(1, 14'd1, 1, 1, 4'b1100, 14'd2, 32'hDEADBEEF,
                      1, 0, 4'h0, 14'd1, 32'h0,  0, 32'h0, 0, 32'h0);
        vecs[13] = mk(0, '0, 1, 1, 4'b1100, 14'd2, 32'hDEADBEEF,
                      0, 1, 4'b1100, 14'd2, 32'hDEADBEEF,  1, 32'h1001, 0, 32'h0);
        vecs[14] = mk(0, '0, 1, 0, 4'h0, 14'd2, 32'h0,  0, 1, 4'h0, 14'd2, 32'h0,  0, 32'h0, 1, 32'h0);
        vecs[15] = mk(0, '0, 0, 0, 4'h0, '0, 32'h0,  0, 0, 4'h0, '0, 32'h0,  0, 32'h0,    1, 32'hDEAD1002);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if_req = vecs[i].ir; if_addr = vecs[i].ia;
            dp_req = vecs[i].dr; dp_we = vecs[i].dw; dp_be = vecs[i].be;
            dp_addr = vecs[i].da; dp_wdata = vecs[i].wd;
            #1;
            got_b = {if_gnt, dp_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                     if_rvalid, if_rdata, dp_rvalid, dp_rdata};
            exp_b = {vecs[i].e_ig, vecs[i].e_dg, vecs[i].e_ig | vecs[i].e_dg,
                     vecs[i].e_we, vecs[i].e_ma, vecs[i].e_mwd,
                     vecs[i].e_iv, vecs[i].e_id, vecs[i].e_dv, vecs[i].e_dd};
            n_vec++;
            if (got_b !== exp_b) begin
                n_err++;
                $display("FAIL vec%0d: got %h expected %h", i, got_b, exp_b);
            end
        end
        #1;
        chk("table cnt_if_wait", cnt_if_wait, 32'd0);
        chk("table cnt_dp_wait", cnt_dp_wait, 32'd1);

        // Continuous contention: dp granted on cycles 4, 9, 14, 19.
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if_req = 1'b1; if_addr = 14'd0;
            dp_req = 1'b1; dp_we = 1'b0; dp_addr = 14'd9;
            #1;
            chk($sformatf("contend dp_gnt c%0d", k), 32'(dp_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("contend if_gnt c%0d", k), 32'(if_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("contend cnt_dp_wait", cnt_dp_wait, 32'd16);
        chk("contend cnt_if_wait", cnt_if_wait, 32'd4);

        // Partial write then read back.
        pulse_reset();
        preload(14'd5, 32'h11223344);
        @(negedge clk);
        dp_req = 1'b1; dp_we = 1'b1; dp_be = 4'b0011; dp_addr = 14'd5; dp_wdata = 32'hAABBCCDD;
        #1;
        chk("wr dp_gnt", 32'(dp_gnt), 32'd1);
        chk("wr mem_we", 32'(mem_we), 32'h3);
        @(negedge clk);
        dp_we = 1'b0; dp_be = 4'b0000; dp_wdata = 32'h0;
        #1;
        chk("wr ack dp_rvalid", 32'(dp_rvalid), 32'd1);
        chk("wr ack dp_rdata", dp_rdata, 32'h0);
        chk("rd dp_gnt", 32'(dp_gnt), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rd dp_rvalid", 32'(dp_rvalid), 32'd1);
        chk("rd dp_rdata", dp_rdata, 32'h1122CCDD);

        // Reset asserted the cycle after a fetch grant drops the response.
        pulse_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 14'd3;
        dp_req = 1'b1; dp_addr = 14'd4;
        #1;
        chk("midrst if_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk);
        chk("midrst pre cnt_dp_wait", cnt_dp_wait, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst if_rvalid", 32'(if_rvalid), 32'd0);
        chk("midrst if_rdata", if_rdata, 32'h0);
        chk("midrst mem_en", 32'(mem_en), 32'd0);
        chk("midrst cnt_dp_wait", cnt_dp_wait, 32'd0);
        chk("midrst cnt_if_wait", cnt_if_wait, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst after if_rvalid", 32'(if_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/itcm_arb.md
# itcm_arb

Two-requester arbiter that shares the single-port instruction TCM between the CPU fetch stage and the CPU data/loader port. It sits between `cpu`'s fetch and execution paths and the ITCM array. It grants one access per cycle, with fetch priority and a starvation guard for the data port. It routes the 1-cycle-latency read data back to the owner and keeps contention counters for the trace bench.

## Interface
- `AW`, 14, ITCM word-address width
- `STARVE`, 4, consecutive denied data-port cycles that force a data-port grant (1..15)

- `clk`  in  1  clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request
- `if_addr`  in  AW  fetch word address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  32  fetch read data
- `dp_req`  in  1  data-port request
- `dp_we`  in  1  1 = write, 0 = read
- `dp_be`  in  4  write byte enables
- `dp_addr`  in  AW  data-port word address
- `dp_wdata`  in  32  write data
- `dp_gnt`  out  1  data-port request accepted this cycle
- `dp_rvalid`  out  1  data-port response (read data or write ack)
- `dp_rdata`  out  32  data-port read data
- `mem_en`  out  1  ITCM enable
- `mem_we`  out  4  ITCM byte write enables
- `mem_addr`  out  AW  ITCM address
- `mem_wdata`  out  32  ITCM write data
- `mem_rdata`  in  32  ITCM read data, valid the cycle after `mem_en` with `mem_we`==0
- `cnt_if_wait`  out  32  cycles `if_req` was high and not granted
- `cnt_dp_wait`  out  32  cycles `dp_req` was high and not granted

## Operation
- **Grant (combinational):** exactly one requester may be granted per cycle.
  - `force` = (`starve_cnt` == `STARVE`).
  - `if_gnt` = `if_req` & !(`dp_req` & `force`).
  - `dp_gnt` = `dp_req` & !`if_gnt`.
- **Memory drive:**
  - `mem_en` = `if_gnt` | `dp_gnt`.
  - The address and write data come from the granted port.
  - `mem_we` = `dp_be` when `dp_gnt` & `dp_we`, else 0.
  - `mem_addr` and `mem_wdata` = 0 when idle.
- **Starvation counter** (`starve_cnt`, 4 bits):
  - Increments while `dp_req` & !`dp_gnt`, saturating at `STARVE`.
  - Clears to 0 on `dp_gnt`.
  - Clears when `dp_req` is low (no grant).
- **Response tracking:** registered `owner` state, one of IDLE, IF_RD, DP_RD, DP_WR.
  - Next state = IF_RD on `if_gnt`; DP_RD or DP_WR on `dp_gnt`; else IDLE.
  - Any state goes to any state every cycle, so back-to-back grants are pipelined with no bubbles.
- **Response outputs:**
  - `if_rvalid` = (`owner`==IF_RD); `if_rdata` = `mem_rdata` when IF_RD, else 0.
  - `dp_rvalid` = (`owner`==DP_RD) | (`owner`==DP_WR); `dp_rdata` = `mem_rdata` when DP_RD, else 0 (write ack carries 0).
- **Counters:**
  - `cnt_if_wait` += 1 when `if_req` & !`if_gnt`.
  - `cnt_dp_wait` += 1 when `dp_req` & !`dp_gnt`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- **Requester rule:** a requester holds address, data and `we` stable while req is high and ungranted. Requests may be withdrawn without penalty.

## Timing
- Grant: 0 cycles (same cycle as req). Read data / write ack: exactly 1 cycle after the grant.
- Throughput: one access per cycle total.
- Under continuous contention, `dp` gets 1 grant per `STARVE`+1 cycles.
- Reset (asynchronous assert, synchronous release). While `reset_n` is low:
  - `owner`=IDLE, `starve_cnt`=0, both counters=0.
  - All `*_rvalid`=0 and all `*_rdata`=0.
  - `if_gnt`, `dp_gnt` and `mem_en` forced 0 regardless of requests.
- Reset asserted mid-operation: the response for an access granted in the previous cycle is dropped (no rvalid). A write granted before reset remains committed to memory.
- First grant is possible in the first cycle with `reset_n` high.
- Simultaneous `if_req` & `dp_req` with `force`: dp wins, `cnt_if_wait` increments, `starve_cnt` clears next cycle.

## Test plan
- **Reset values:** reset_n=0 with `if_req`=`dp_req`=1 → all grants, rvalids, `mem_en` and counters = 0; release → `if_gnt`=1 in the same cycle.
- **Fetch stream:** `if_req`=1 for 8 cycles, addr 0..7, memory preloaded word[i]=0x1000+i → `if_rvalid` 8 consecutive cycles, each one cycle after its grant, data 0x1000..0x1007.
- **Contention, STARVE=4:** both req held 20 cycles → dp granted on cycles 4, 9, 14, 19 (0-based); `cnt_dp_wait`=16, `cnt_if_wait`=4.
- **Write then read:** dp write addr 5, be=0b0011, wdata 0xAABBCCDD over old 0x11223344 → `dp_rvalid`=1 with `dp_rdata`=0 next cycle; dp read addr 5 → `dp_rdata`=0x1122CCDD.
- **Mid-operation reset:** fetch granted at cycle N, reset_n=0 at cycle N+1 before edge → no `if_rvalid`, counters 0.
- **Counter wrap:** preload `cnt_if_wait`=0xFFFFFFFF via force, one denied fetch cycle → 0x00000000.
